hex_field_scheduler: RTL and testbench
======================================

Name: hex_field_scheduler

Overview:
- Sequences a row of seven-segment digit renderers across the VGA active area so one renderer instance draws a multi-digit hexadecimal field.
- Tracks the beam pixel by pixel. Works out which digit cell the beam is in, and presents that cell's nibble and centre coordinates to the renderer.
- Pixel coordinates are delayed by the same amount so they stay aligned with the digit and centre.
- Holds a frame-synchronised snapshot of the displayed value, loaded through a valid/ready handshake, so the digits never tear mid-frame.

Parameters:
- DIGITS, 8, number of hex digits; value width is 4*DIGITS.
- CELL_W, 80, horizontal pitch of one digit cell in pixels.
- ORIGIN_X, 60, cx of digit 0 (most significant nibble).
- ORIGIN_Y, 240, cy of every digit.
- BAND_H, 25, half-height of the active row band; rows ORIGIN_Y-BAND_H .. ORIGIN_Y+BAND_H are inclusive.

Ports:
- clk  in  1  pixel-domain clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  x/y are valid and advance this cycle
- x  in  11  current beam column
- y  in  11  current beam row
- value  in  4*DIGITS  value to display
- value_valid  in  1  value offered
- value_ready  out  1  pending slot empty
- digit  out  4  nibble for the current cell
- cx  out  11  centre x of the current cell
- cy  out  11  centre y (= ORIGIN_Y while active)
- px  out  11  x delayed to align with digit/cx
- py  out  11  y delayed to align with digit/cx
- active  out  1  beam is inside a digit cell; the renderer output is ANDed with this

Behaviour:
- Reset (asynchronous, rst_n=0):
  - display register = 0, pending empty, value_ready = 1.
  - FSM = IDLE, cell index = 0, cell offset = 0.
  - digit = 0, cx = 0, cy = 0, px = 0, py = 0, active = 0.
  - Reset mid-line aborts the scan immediately; the first frame after reset shows 0.
- Handshake:
  - Transfer occurs when value_valid && value_ready on a rising edge; value goes to the pending register and value_ready drops the next cycle.
  - value_valid with value_ready = 0 is not accepted; the source must hold it.
- Frame start: the cycle with pix_en && x==0 && y==0.
  - If pending is full: display <= pending, pending is emptied, and value_ready rises the next cycle.
  - If pending is empty and a transfer happens in that same cycle: the transferred value bypasses straight into display and pending stays empty.
  - Otherwise display is unchanged.
- Cell geometry:
  - X0 = ORIGIN_X - CELL_W/2.
  - Cell k spans X0+k*CELL_W .. X0+(k+1)*CELL_W-1.
  - cx = ORIGIN_X + k*CELL_W; computed incrementally (add CELL_W per cell), with no multiplier.
  - digit = display[4*(DIGITS-1-k) +: 4].
  - All coordinate arithmetic is 11-bit unsigned and must not wrap with the default parameters.
- FSM, evaluated only when pix_en=1; with pix_en=0 all state and outputs hold:
  - IDLE -> SCAN when x==X0 and y is in the band; index = 0, offset = 0.
  - SCAN: offset++. When offset==CELL_W-1: offset = 0 and index++. When that wrap happens with index==DIGITS-1, go to DONE.
  - DONE -> IDLE when x==0, which is the next line.
  - Row leaving the band while in SCAN: forced to DONE.
  - x==0 in any state forces IDLE. It realigns on a short or odd line.
- Outputs:
  - Registered with 1-cycle latency from the pix_en sample. px/py carry that sample's x/y.
  - active = 1 exactly for samples taken while the FSM is in SCAN, including the X0 entry sample; otherwise 0. digit and cx are don't-care when active = 0.
  - cy = ORIGIN_Y when active, else 0.

Test Plan:
- Reset release, no load, full frame -> active high only on rows 215..265, x = 20..659; digit = 0 throughout; cx steps 60, 140, ..., 620.
- Load 0x0123ABCD before frame start -> the next frame's cells 0..7 output digits 0,1,2,3,A,B,C,D; the current frame is unchanged.
- Offer 0x11111111 then 0x22222222 in the same frame -> the first is accepted, value_ready = 0 and the second is held off. At frame start display = 0x11111111, and the second is accepted on the following cycle.
- Transfer 0xFFFFFFFF on exactly the frame-start cycle with pending empty -> that same frame displays FFFFFFFF and value_ready stays 1.
- Toggle pix_en 1/0 every cycle across one line -> cell boundaries still fall on x = 100, 180, ...; px tracks x with a 1-sample delay.
- Assert rst_n=0 mid-cell in row 240 -> all outputs 0 immediately; after release, scanning resumes at the next x==X0 in the band.

Source files
------------

// File: rtl/hex_field_scheduler.sv
// Beam-driven sequencer that steps one seven-segment renderer across a row of
// hex digit cells, with a frame-synchronised value snapshot loaded via valid/ready.
module hex_field_scheduler #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned CELL_W   = 80,
  parameter int unsigned ORIGIN_X = 60,
  parameter int unsigned ORIGIN_Y = 240,
  parameter int unsigned BAND_H   = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_en,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  value_valid,
  output logic                  value_ready,
  output logic [3:0]            digit,
  output logic [10:0]           cx,
  output logic [10:0]           cy,
  output logic [10:0]           px,
  output logic [10:0]           py,
  output logic                  active
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned OW = (CELL_W > 1) ? $clog2(CELL_W) : 1;

  localparam logic [10:0]   X0       = 11'(ORIGIN_X - CELL_W / 2);
  localparam logic [10:0]   Y_LO     = 11'(ORIGIN_Y - BAND_H);
  localparam logic [10:0]   Y_HI     = 11'(ORIGIN_Y + BAND_H);
  localparam logic [10:0]   CX0      = 11'(ORIGIN_X);
  localparam logic [10:0]   CY0      = 11'(ORIGIN_Y);
  localparam logic [10:0]   STEP     = 11'(CELL_W);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [OW-1:0] OFF_LAST = OW'(CELL_W - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [OW-1:0]   off_q, off_d;
  logic [10:0]     cxa_q, cxa_d;
  logic [VW-1:0]   disp_q, disp_d;
  logic [VW-1:0]   pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic [3:0]      digit_q, digit_d;
  logic [10:0]     cx_q, cx_d;
  logic [10:0]     cy_q, cy_d;
  logic [10:0]     px_q, px_d;
  logic [10:0]     py_q, py_d;
  logic            active_q, active_d;

  logic            xfer;
  logic            frame_start;
  logic            in_band;
  logic            sample_act;
  logic [3:0]      nib;

  assign value_ready = ~pend_full_q;
  assign xfer        = value_valid & ~pend_full_q;
  assign frame_start = pix_en && (x == '0) && (y == '0);
  assign in_band     = (y >= Y_LO) && (y <= Y_HI);

  // An offer landing on the frame-start cycle skips the pending slot entirely.
  always_comb begin
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (frame_start && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end else if (frame_start && xfer) begin
      disp_d = value;
    end else if (xfer) begin
      pend_d      = value;
      pend_full_d = 1'b1;
    end
  end

  // The cell state is advanced before the sample is classified, so the
  // registered outputs describe the cell this sample actually falls in.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    off_d      = off_q;
    cxa_d      = cxa_q;
    sample_act = 1'b0;
    if (pix_en) begin
      if (x == '0) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (x == X0 && in_band) begin
              state_d    = SCAN;
              idx_d      = '0;
              off_d      = '0;
              cxa_d      = CX0;
              sample_act = 1'b1;
            end
          end
          SCAN: begin
            if (!in_band) begin
              state_d = DONE;
            end else if (off_q == OFF_LAST) begin
              if (idx_q == IDX_LAST) begin
                state_d = DONE;
              end else begin
                idx_d      = idx_q + IW'(1);
                off_d      = '0;
                cxa_d      = cxa_q + STEP;
                sample_act = 1'b1;
              end
            end else begin
              off_d      = off_q + OW'(1);
              sample_act = 1'b1;
            end
          end
          DONE:    state_d = DONE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    nib = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_d == IW'(k)) nib = disp_q[4*(DIGITS-1-k) +: 4];
    end
  end

  always_comb begin
    digit_d  = digit_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    px_d     = px_q;
    py_d     = py_q;
    active_d = active_q;
    if (pix_en) begin
      active_d = sample_act;
      px_d     = x;
      py_d     = y;
      cy_d     = sample_act ? CY0   : '0;
      cx_d     = sample_act ? cxa_d : '0;
      digit_d  = sample_act ? nib   : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      off_q       <= '0;
      cxa_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      digit_q     <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      px_q        <= '0;
      py_q        <= '0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      cxa_q       <= cxa_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      digit_q     <= digit_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      px_q        <= px_d;
      py_q        <= py_d;
      active_q    <= active_d;
    end
  end

  assign digit  = digit_q;
  assign cx     = cx_q;
  assign cy     = cy_q;
  assign px     = px_q;
  assign py     = py_q;
  assign active = active_q;

endmodule

// File: tb/tb_hex_field_scheduler.sv
// Scoreboard bench for hex_field_scheduler: expected pixels are queued as the
// beam is driven and compared one cycle later; display/pending are modelled here.
module tb_hex_field_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [10:0] x = '0;
  logic [10:0] y = '0;
  logic [31:0] value = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic [3:0]  digit;
  logic [10:0] cx, cy, px, py;
  logic        active;

  always #5 clk = ~clk;

  hex_field_scheduler #(
    .DIGITS(8), .CELL_W(80), .ORIGIN_X(60), .ORIGIN_Y(240), .BAND_H(25)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x), .y(y),
    .value(value), .value_valid(value_valid), .value_ready(value_ready),
    .digit(digit), .cx(cx), .cy(cy), .px(px), .py(py), .active(active)
  );

  typedef struct {
    logic        act;
    logic [3:0]  dig;
    logic [10:0] cx;
    logic [10:0] cy;
    logic [10:0] px;
    logic [10:0] py;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        last_exp;
  exp_t        mon_e;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [31:0] md = '0;
  logic [31:0] mp = '0;
  bit          mfull = 1'b0;
  bit          blank_line = 1'b0;

  // Scoreboard consumer: one expected entry per clocked sample.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if (active !== mon_e.act || cy !== mon_e.cy || px !== mon_e.px || py !== mon_e.py ||
          (mon_e.act && (digit !== mon_e.dig || cx !== mon_e.cx))) begin
        n_bad++;
        $display("FAIL pixel px=%0d py=%0d: got act=%b dig=%h cx=%0d cy=%0d px=%0d py=%0d, want act=%b dig=%h cx=%0d cy=%0d px=%0d py=%0d",
                 mon_e.px, mon_e.py, active, digit, cx, cy, px, py,
                 mon_e.act, mon_e.dig, mon_e.cx, mon_e.cy, mon_e.px, mon_e.py);
      end
    end
  end

  task automatic drive(input logic [10:0] xi, input logic [10:0] yi, input bit en,
                       input bit vv, input logic [31:0] vval);
    exp_t        e;
    bit          xfer;
    bit          fs;
    int unsigned k;
    @(negedge clk);
    x = xi; y = yi; pix_en = en; value_valid = vv; value = vval;
    n_vec++;
    if (value_ready !== logic'(!mfull)) begin
      n_bad++;
      $display("FAIL value_ready x=%0d y=%0d: got %b want %b", xi, yi, value_ready, !mfull);
    end
    if (en) begin
      if (xi == 0) blank_line = 1'b0;
      e.px  = xi;
      e.py  = yi;
      e.act = !blank_line && yi >= 215 && yi <= 265 && xi >= 20 && xi <= 659;
      k     = e.act ? (int'(xi) - 20) / 80 : 0;
      e.cx  = e.act ? 11'(60 + 80 * k) : '0;
      e.cy  = e.act ? 11'd240 : '0;
      e.dig = e.act ? md[4*(7-k) +: 4] : '0;
      last_exp = e;
    end else begin
      e = last_exp;
    end
    exp_q.push_back(e);
    xfer = vv && !mfull;
    fs   = en && xi == 0 && yi == 0;
    if (fs && mfull) begin
      md = mp; mfull = 1'b0;
    end else if (fs && xfer) begin
      md = vval;
    end else if (xfer) begin
      mp = vval; mfull = 1'b1;
    end
  endtask

  task automatic line(input logic [10:0] yi, input int xs, input bit tog,
                      input bit vv, input logic [31:0] vval);
    for (int i = xs; i < 700; i++) begin
      drive(11'(i), yi, 1'b1, vv, vval);
      if (tog) drive('0, '0, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic rest_of_frame();
    line(11'd214, 0, 1'b0, 1'b0, '0);
    line(11'd215, 0, 1'b0, 1'b0, '0);
    line(11'd240, 0, 1'b0, 1'b0, '0);
    line(11'd265, 0, 1'b0, 1'b0, '0);
    line(11'd266, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic frame();
    line(11'd0, 0, 1'b0, 1'b0, '0);
    rest_of_frame();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (active !== 1'b0 || digit !== 4'h0 || cx !== '0 || cy !== '0 || px !== '0 ||
        py !== '0 || value_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: got act=%b dig=%h cx=%0d cy=%0d px=%0d py=%0d rdy=%b, want all 0 with rdy=1",
               active, digit, cx, cy, px, py, value_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_blank_frame();
    frame();
  endtask

  task automatic test_load();
    line(11'd0, 0, 1'b0, 1'b0, '0);
    line(11'd214, 0, 1'b0, 1'b0, '0);
    drive(11'd0, 11'd215, 1'b1, 1'b1, 32'h0123ABCD);
    line(11'd215, 1, 1'b0, 1'b0, '0);
    line(11'd240, 0, 1'b0, 1'b0, '0);
    line(11'd265, 0, 1'b0, 1'b0, '0);
    line(11'd266, 0, 1'b0, 1'b0, '0);
    frame();
  endtask

  task automatic test_back_to_back();
    line(11'd0, 0, 1'b0, 1'b0, '0);
    drive(11'd0, 11'd214, 1'b1, 1'b1, 32'h11111111);
    line(11'd214, 1, 1'b0, 1'b1, 32'h22222222);
    line(11'd215, 0, 1'b0, 1'b1, 32'h22222222);
    line(11'd240, 0, 1'b0, 1'b1, 32'h22222222);
    line(11'd265, 0, 1'b0, 1'b1, 32'h22222222);
    line(11'd266, 0, 1'b0, 1'b1, 32'h22222222);
    drive(11'd0, 11'd0, 1'b1, 1'b1, 32'h22222222);
    drive(11'd1, 11'd0, 1'b1, 1'b1, 32'h22222222);
    line(11'd0, 2, 1'b0, 1'b0, '0);
    rest_of_frame();
    n_vec++;
    if (md !== 32'h11111111 || value_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL back_to_back_hold: got model_disp=%h rdy=%b, want 11111111 rdy=0", md, value_ready);
    end
    frame();
  endtask

  task automatic test_bypass();
    drive(11'd0, 11'd0, 1'b1, 1'b1, 32'hFFFFFFFF);
    line(11'd0, 1, 1'b0, 1'b0, '0);
    rest_of_frame();
    n_vec++;
    if (value_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bypass_ready: got %b want 1", value_ready);
    end
  endtask

  task automatic test_pix_en_toggle();
    line(11'd240, 0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i <= 300; i++) drive(11'(i), 11'd240, 1'b1, 1'b0, '0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (active !== 1'b0 || digit !== 4'h0 || cx !== '0 || cy !== '0 || px !== '0 ||
        py !== '0 || value_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_midline: got act=%b dig=%h cx=%0d cy=%0d px=%0d py=%0d rdy=%b, want all 0 with rdy=1",
               active, digit, cx, cy, px, py, value_ready);
    end
    exp_q.delete();
    md = '0; mp = '0; mfull = 1'b0; blank_line = 1'b1;
    last_exp = '{default: '0};
    pix_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 301; i < 700; i++) drive(11'(i), 11'd240, 1'b1, 1'b0, '0);
    frame();
  endtask

  initial begin
    last_exp = '{default: '0};
    test_reset();
    test_blank_frame();
    test_load();
    test_back_to_back();
    test_bypass();
    test_pix_en_toggle();
    test_reset_midline();
    @(negedge clk);
    pix_en = 1'b0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
